// File: rtl/jerky_arbiter.sv
// Two-requester round-robin arbiter that grants a shared counter for fixed-length bursts.
// Optional per-requester grant statistics are enabled with `define JERKY_ARB_STATS_EN.
module jerky_arbiter #(
  parameter int unsigned COUNTER_SIZE = 5,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned BL_W         = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [1:0]      req_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      done_o,
  output logic            busy_o,
  output logic            ctr_reset_n_o,
  output logic            ctr_enable_o,
  output logic [BL_W-1:0] burst_cnt_o
`ifdef JERKY_ARB_STATS_EN
  ,
  output logic [7:0]      grant_cnt0_o,
  output logic [7:0]      grant_cnt1_o
`endif
);

  if (BURST_LEN < 1 || BURST_LEN > (2 ** BL_W) - 1 || COUNTER_SIZE < 1) begin : g_bad_param
    $error("jerky_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  localparam logic [BL_W-1:0] LastCnt = BL_W'(BURST_LEN - 1);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic            busy_q, busy_d;
  logic            ctr_rst_n_q, ctr_rst_n_d;
  logic            ctr_en_q, ctr_en_d;
  logic [BL_W-1:0] cnt_q, cnt_d;
  logic            winner;

  // On a tie the requester that did not own the last burst wins.
  always_comb begin
    winner = ~last_owner_q;
    if (req_i == 2'b01) begin
      winner = 1'b0;
    end else if (req_i == 2'b10) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StClear;
          owner_d = winner;
        end
      end
      StClear: begin
        if (!req_i[owner_q]) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!req_i[owner_q]) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d      = StIdle;
        last_owner_d = owner_q;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    gnt_d       = (state_d == StClear || state_d == StRun) ? (2'b01 << owner_d) : 2'b00;
    done_d      = (state_d == StDone) ? (2'b01 << owner_d) : 2'b00;
    busy_d      = (state_d != StIdle);
    ctr_rst_n_d = (state_d != StClear);
    ctr_en_d    = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
      ctr_rst_n_q  <= 1'b0;
      ctr_en_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ctr_rst_n_q  <= ctr_rst_n_d;
      ctr_en_q     <= ctr_en_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign ctr_reset_n_o = ctr_rst_n_q;
  assign ctr_enable_o  = ctr_en_q;
  assign burst_cnt_o   = cnt_q;

`ifdef JERKY_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt1_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_cnt0_q <= 8'd0;
      grant_cnt1_q <= 8'd0;
    end else if (state_q == StDone) begin
      if (!owner_q && grant_cnt0_q != 8'hff) grant_cnt0_q <= grant_cnt0_q + 8'd1;
      if (owner_q && grant_cnt1_q != 8'hff) grant_cnt1_q <= grant_cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_jerky_arbiter.sv
// Scoreboard bench for jerky_arbiter: BURST_LEN=16 instance plus a BURST_LEN=1 instance.
// Expected per-cycle snapshots and done pulses are queued by stimulus and checked by a monitor.
module tb_jerky_arbiter;

  localparam int BL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [1:0] req = 2'b00, req1 = 2'b00;
  logic [1:0] gnt_o, done_o, gnt1, done1;
  logic       busy_o, rn_o, en_o, busy1, rn1, en1;
  logic [4:0] cnt_o, cnt1;
`ifdef JERKY_ARB_STATS_EN
  logic [7:0] gc0, gc1, gc0b, gc1b;
`endif

  jerky_arbiter u_dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .gnt_o(gnt_o), .done_o(done_o),
    .busy_o(busy_o), .ctr_reset_n_o(rn_o), .ctr_enable_o(en_o), .burst_cnt_o(cnt_o)
`ifdef JERKY_ARB_STATS_EN
    , .grant_cnt0_o(gc0), .grant_cnt1_o(gc1)
`endif
  );

  jerky_arbiter #(.BURST_LEN(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .req_i(req1), .gnt_o(gnt1), .done_o(done1),
    .busy_o(busy1), .ctr_reset_n_o(rn1), .ctr_enable_o(en1), .burst_cnt_o(cnt1)
`ifdef JERKY_ARB_STATS_EN
    , .grant_cnt0_o(gc0b), .grant_cnt1_o(gc1b)
`endif
  );

  typedef struct {
    int         inst;
    int         cyc;
    logic [11:0] v;
  } exp_t;
  typedef struct {
    int         cyc;
    logic [1:0] val;
  } dn_t;

  exp_t sq[$];
  dn_t  dq0[$], dq1[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  bit mon_on = 1'b0, fin_req = 1'b0, fin_done = 1'b0;

  function automatic logic [11:0] pk(logic [1:0] g, logic [1:0] d, logic en, logic rn,
                                     logic b, logic [4:0] c);
    return {g, d, en, rn, b, c};
  endfunction

  localparam logic [11:0] IdleV = {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0};
  localparam logic [11:0] RstV  = 12'd0;

  task automatic exp_at(input int inst, input int c, input logic [11:0] v);
    exp_t e;
    e.inst = inst;
    e.cyc  = c;
    e.v    = v;
    sq.push_back(e);
  endtask

  // Cycle c0 is the IDLE cycle in which the request is sampled; pushes cycles c0+1..c0+upto.
  task automatic exp_burst(input int inst, input int c0, input int owner, input int bl,
                           input int upto);
    logic [1:0] g;
    dn_t d;
    g = (owner == 1) ? 2'b10 : 2'b01;
    for (int k = 1; k <= upto; k++) begin
      if (k == 1) begin
        exp_at(inst, c0 + k, pk(g, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0));
      end else if (k <= bl + 1) begin
        exp_at(inst, c0 + k, pk(g, 2'b00, 1'b1, 1'b1, 1'b1, 5'(k - 2)));
      end else begin
        exp_at(inst, c0 + k, pk(2'b00, g, 1'b0, 1'b1, 1'b1, 5'd0));
        d.cyc = c0 + k;
        d.val = g;
        if (inst == 0) dq0.push_back(d);
        else dq1.push_back(d);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_at(0, cyc + 1, RstV);
    exp_at(1, cyc + 1, RstV);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_at(0, cyc + 1, IdleV);
    exp_at(1, cyc + 1, IdleV);
    tick(1);
  endtask

  exp_t        me;
  dn_t         md;
  logic [11:0] act;

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (!$onehot0(gnt_o) || !$onehot0(done_o) || !$onehot0(gnt1) || !$onehot0(done1)) begin
        failures++;
        $display("FAIL onehot cyc=%0d gnt=%b done=%b gnt1=%b done1=%b", cyc, gnt_o, done_o,
                 gnt1, done1);
      end
      if (done_o != 2'b00) begin
        checks++;
        if (dq0.size() == 0) begin
          failures++;
          $display("FAIL done0 cyc=%0d got=%b expected no pulse", cyc, done_o);
        end else begin
          md = dq0.pop_front();
          if (md.cyc != cyc || md.val != done_o) begin
            failures++;
            $display("FAIL done0 got=%b@%0d expected=%b@%0d", done_o, cyc, md.val, md.cyc);
          end
        end
      end
      if (done1 != 2'b00) begin
        checks++;
        if (dq1.size() == 0) begin
          failures++;
          $display("FAIL done1 cyc=%0d got=%b expected no pulse", cyc, done1);
        end else begin
          md = dq1.pop_front();
          if (md.cyc != cyc || md.val != done1) begin
            failures++;
            $display("FAIL done1 got=%b@%0d expected=%b@%0d", done1, cyc, md.val, md.cyc);
          end
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        me = sq.pop_front();
        checks++;
        act = (me.inst == 1) ? pk(gnt1, done1, en1, rn1, busy1, cnt1)
                             : pk(gnt_o, done_o, en_o, rn_o, busy_o, cnt_o);
        if (me.cyc != cyc || act !== me.v) begin
          failures++;
          $display("FAIL snap inst%0d cyc=%0d got{gnt,done,en,rn,busy,cnt}=%b expected=%b@%0d",
                   me.inst, cyc, act, me.v, me.cyc);
        end
      end
      if (fin_req && !fin_done) begin
        checks++;
        if (sq.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
          failures++;
          $display("FAIL leftover got snap=%0d done0=%0d done1=%0d expected 0", sq.size(),
                   dq0.size(), dq1.size());
        end
`ifdef JERKY_ARB_STATS_EN
        checks++;
        if (gc0 !== 8'd255 || gc1 !== 8'd0) begin
          failures++;
          $display("FAIL stats got cnt0=%0d cnt1=%0d expected 255/0", gc0, gc1);
        end
`endif
        fin_done = 1'b1;
      end
    end
  end

  int c;

  initial begin
    tick(3);
    mon_on = 1'b1;
    do_reset();

    // Single requester, with non-owner request noise mid-burst.
    c = cyc;
    req = 2'b01;
    exp_burst(0, c, 0, BL, BL + 2);
    tick(5);
    req = 2'b11;
    tick(5);
    req = 2'b01;
    tick(8);
    req = 2'b00;
    exp_at(0, c + 19, IdleV);
    tick(1);

    // Both requesting from reset: grants alternate 0,1,0.
    do_reset();
    c = cyc;
    req = 2'b11;
    exp_burst(0, c, 0, BL, BL + 2);
    exp_at(0, c + 19, IdleV);
    exp_burst(0, c + 19, 1, BL, BL + 2);
    exp_at(0, c + 38, IdleV);
    exp_burst(0, c + 38, 0, BL, BL + 2);
    tick(56);
    req = 2'b00;
    exp_at(0, c + 57, IdleV);
    tick(1);

    // Requester 1 aborts in its 5th RUN cycle; the following tie goes to requester 0.
    c = cyc;
    req = 2'b10;
    exp_burst(0, c, 1, BL, 6);
    tick(6);
    req = 2'b00;
    exp_at(0, c + 7, IdleV);
    tick(1);
    req = 2'b11;
    exp_burst(0, c + 7, 0, BL, BL + 2);
    tick(18);
    req = 2'b00;
    exp_at(0, c + 26, IdleV);
    tick(1);

    // Reset during the 8th RUN cycle.
    c = cyc;
    req = 2'b01;
    exp_burst(0, c, 0, BL, 9);
    tick(9);
    req = 2'b00;
    do_reset();

    // BURST_LEN=1 instance: one enabled cycle, done at cycle 3.
    c = cyc;
    req1 = 2'b01;
    exp_burst(1, c, 0, 1, 3);
    tick(3);
    req1 = 2'b00;
    exp_at(1, c + 4, IdleV);
    tick(1);

`ifdef JERKY_ARB_STATS_EN
    do_reset();
    c = cyc;
    req = 2'b01;
    for (int i = 0; i < 300; i++) begin
      md.cyc = c + 19 * i + 18;
      md.val = 2'b01;
      dq0.push_back(md);
    end
    tick(299 * 19 + 18);
    req = 2'b00;
    tick(2);
`endif

    fin_req = 1'b1;
    wait (fin_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
